// File: rtl/bsram_arb_pkg.sv
// Shared types and helpers for the BSRAM round-robin arbiter.
// The command struct is sized for the largest supported build (8 requesters, 32-bit address, 64-bit data).
package bsram_arb_pkg;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam int CMD_ID_W   = 3;
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 64;

   typedef struct packed {
      logic [CMD_ID_W-1:0]   id;
      logic                  write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } cmd_t;

   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping modulo N.
// Produces a one-hot grant plus the binary index of the winner.
module rr_pick
   import bsram_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  valid,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] winner,
   output logic          any
);

   // Outer loop walks the scan distance from ptr, inner loop finds the matching index.
   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!any && valid[i] && (((int'(ptr) + k) % N) == i)) begin
               any      = 1'b1;
               grant[i] = 1'b1;
               winner   = PW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/bsram_arbiter.sv
// Round-robin arbiter sharing one BSRAM between NUM_REQ requesters: one command stage, one response stage.
// Optional per-requester grant counters and report hook when BSRAM_ARB_STATS_EN is defined.
module bsram_arbiter
   import bsram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_data,
   output logic                          mem_readEnable,
   output logic [ADDR_WIDTH-1:0]         mem_readAddress,
   input  logic [DATA_WIDTH-1:0]         mem_readData,
   output logic                          mem_writeEnable,
   output logic [ADDR_WIDTH-1:0]         mem_writeAddress,
   output logic [DATA_WIDTH-1:0]         mem_writeData
`ifdef BSRAM_ARB_STATS_EN
   ,
   input  logic                          report,
   output logic [NUM_REQ*32-1:0]         stat_grants
`endif
);

   localparam int PW = clog2_min1(NUM_REQ);

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   logic [NUM_REQ-1:0]    grant;
   logic [PW-1:0]         winner;
   logic                  any_valid;
   logic                  accept;

   logic [PW-1:0]         rr_ptr_reg;
   logic [PW-1:0]         rr_ptr_next;
   cmd_t                  cmd_reg;
   cmd_t                  cmd_next;
   logic                  cmd_valid_reg;
   logic [NUM_REQ-1:0]    resp_valid_reg;
   logic [DATA_WIDTH-1:0] resp_data_reg;

   logic [PW-1:0]         cmd_id;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  unused_cmd_bits;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .valid  (req_valid),
      .ptr    (rr_ptr_reg),
      .grant  (grant),
      .winner (winner),
      .any    (any_valid)
   );

   assign req_ready = reset ? '0 : grant;
   assign accept    = any_valid & ~reset;

   always_comb begin
      rr_ptr_next = '0;
      if (int'(winner) != NUM_REQ - 1) rr_ptr_next = winner + 1'b1;
   end

   always_comb begin
      cmd_next       = '0;
      cmd_next.id    = CMD_ID_W'(winner);
      cmd_next.write = req_write[winner];
      cmd_next.addr  = CMD_ADDR_W'(addr_arr[winner]);
      cmd_next.wdata = CMD_DATA_W'(wdata_arr[winner]);
   end

   assign cmd_id          = cmd_reg.id[PW-1:0];
   assign cmd_addr        = cmd_reg.addr[ADDR_WIDTH-1:0];
   assign cmd_wdata       = cmd_reg.wdata[DATA_WIDTH-1:0];
   // Upper struct bits beyond this build's widths are constant zero.
   assign unused_cmd_bits = ^cmd_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_reg     <= '0;
         cmd_valid_reg  <= 1'b0;
         cmd_reg        <= '0;
         resp_valid_reg <= '0;
         resp_data_reg  <= '0;
      end else begin
         cmd_valid_reg <= accept;
         if (accept) begin
            cmd_reg    <= cmd_next;
            rr_ptr_reg <= rr_ptr_next;
         end
         resp_valid_reg <= cmd_valid_reg ? (NUM_REQ'(1) << cmd_id) : '0;
         if (cmd_valid_reg)
            resp_data_reg <= (cmd_reg.write == CMD_WRITE) ? '0 : mem_readData;
      end
   end

   assign resp_valid = resp_valid_reg;
   assign resp_data  = resp_data_reg;

   // Gating with reset keeps a discarded write from landing in the BSRAM.
   always_comb begin
      mem_readEnable   = 1'b0;
      mem_readAddress  = '0;
      mem_writeEnable  = 1'b0;
      mem_writeAddress = '0;
      mem_writeData    = '0;
      if (cmd_valid_reg && !reset) begin
         if (cmd_reg.write == CMD_READ) begin
            mem_readEnable  = 1'b1;
            mem_readAddress = cmd_addr;
         end else begin
            mem_writeEnable  = 1'b1;
            mem_writeAddress = cmd_addr;
            mem_writeData    = cmd_wdata;
         end
      end
   end

`ifdef BSRAM_ARB_STATS_EN
   logic [31:0] grant_cnt_reg [NUM_REQ];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) grant_cnt_reg[i] <= '0;
      end else if (accept) begin
         grant_cnt_reg[winner] <= grant_cnt_reg[winner] + 32'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
         assign stat_grants[gi*32 +: 32] = grant_cnt_reg[gi];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (report) begin
         for (int i = 0; i < NUM_REQ; i++)
            $display("bsram_arbiter: grants[%0d]=%0d", i, grant_cnt_reg[i]);
         $display("bsram_arbiter: cmd valid=%0b id=%0d write=%0b addr=%h wdata=%h",
                  cmd_valid_reg, cmd_id, cmd_reg.write, cmd_addr, cmd_wdata);
      end
   end
`endif

endmodule

// File: tb/tb_bsram_arbiter.sv
// Self-checking bench for bsram_arbiter: vector table, directed corner sequences, random traffic vs. a model.
// Build with BSRAM_ARB_STATS_EN defined to also exercise the grant counters.
module tb_bsram_arbiter;

   localparam int NR = 2;
   localparam int DW = 32;
   localparam int AW = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_write;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     resp_valid;
   logic [DW-1:0]     resp_data;
   logic              mem_readEnable;
   logic [AW-1:0]     mem_readAddress;
   logic [DW-1:0]     mem_readData;
   logic              mem_writeEnable;
   logic [AW-1:0]     mem_writeAddress;
   logic [DW-1:0]     mem_writeData;
`ifdef BSRAM_ARB_STATS_EN
   logic              report = 1'b0;
   logic [NR*32-1:0]  stat_grants;
`endif

   bsram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock            (clock),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_write        (req_write),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_ready        (req_ready),
      .resp_valid       (resp_valid),
      .resp_data        (resp_data),
      .mem_readEnable   (mem_readEnable),
      .mem_readAddress  (mem_readAddress),
      .mem_readData     (mem_readData),
      .mem_writeEnable  (mem_writeEnable),
      .mem_writeAddress (mem_writeAddress),
      .mem_writeData    (mem_writeData)
`ifdef BSRAM_ARB_STATS_EN
      ,
      .report           (report),
      .stat_grants      (stat_grants)
`endif
   );

   always #5 clock = ~clock;

   // BSRAM model: same-cycle read, write on the rising edge; preloaded on its first edge.
   logic [DW-1:0] tb_mem [256];
   logic          mem_init_done = 1'b0;
   assign mem_readData = tb_mem[mem_readAddress];

   always @(posedge clock) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
         tb_mem[1] <= 32'h1111_1111;
         tb_mem[2] <= 32'h2222_2222;
         mem_init_done <= 1'b1;
      end else if (mem_writeEnable) begin
         tb_mem[mem_writeAddress] <= mem_writeData;
      end
   end

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  exp_ready;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [12];

   // Single-requester transaction: grant, command-cycle BSRAM pins, then tagged response.
   task automatic do_op(input int id, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d, input string tag);
      @(negedge clock);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_write[id] = w;
      req_addr[id*AW +: AW]  = a;
      req_wdata[id*DW +: DW] = d;
      #1;
      check({tag, "_ready"}, 64'(req_ready), 64'(2'b01 << id));
      @(posedge clock);
      #1 req_valid = '0;
      @(negedge clock);
      if (w) begin
         check({tag, "_wen"}, 64'({mem_writeEnable, mem_readEnable}), 64'(2'b10));
         check({tag, "_waddr"}, 64'(mem_writeAddress), 64'(a));
         check({tag, "_wdata"}, 64'(mem_writeData), 64'(d));
      end else begin
         check({tag, "_ren"}, 64'({mem_writeEnable, mem_readEnable}), 64'(2'b01));
         check({tag, "_raddr"}, 64'(mem_readAddress), 64'(a));
      end
      @(negedge clock);
      check({tag, "_resp_valid"}, 64'(resp_valid), 64'(2'b01 << id));
      check({tag, "_resp_data"}, 64'(resp_data), 64'(exp_d));
      $display("op %s: req%0d %s addr=%h resp_valid=%b resp_data=%h", tag, id, w ? "wr" : "rd",
               a, resp_valid, resp_data);
   endtask

   // Random-phase model state
   logic          hold  [NR];
   logic          hw    [NR];
   logic [7:0]    ha    [NR];
   logic [31:0]   hd    [NR];
   logic [31:0]   ref_mem [256];
   int            rr_m, win;
   logic          pend_v, pend_w;
   int            pend_id;
   logic [7:0]    pend_a;
   logic [31:0]   pend_d;
   logic [1:0]    exp_rv;
   logic [31:0]   exp_rd;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset holds grants and BSRAM enables low even with requests present.
      repeat (3) @(negedge clock);
      req_valid = 2'b11;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         check("rst_ready", 64'(req_ready), 64'h0);
         check("rst_mem_en", 64'({mem_readEnable, mem_writeEnable}), 64'h0);
         check("rst_resp_valid", 64'(resp_valid), 64'h0);
         $display("reset cycle %0d: ready=%b", c, req_ready);
      end
      req_valid = '0;
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         check("idle_resp_valid", 64'(resp_valid), 64'h0);
         check("idle_mem_en", 64'({mem_readEnable, mem_writeEnable}), 64'h0);
         check("idle_ready", 64'(req_ready), 64'h0);
         $display("idle cycle %0d: resp_valid=%b", c, resp_valid);
      end

      // Arbitration table: r0 reads 0x01, r1 reads 0x02; rr_ptr starts at 0.
      tbl[0]  = '{2'b00, 2'b00, 2'b00, 32'h0};
      tbl[1]  = '{2'b11, 2'b01, 2'b00, 32'h0};
      tbl[2]  = '{2'b11, 2'b10, 2'b00, 32'h0};
      tbl[3]  = '{2'b10, 2'b10, 2'b01, 32'h1111_1111};
      tbl[4]  = '{2'b01, 2'b01, 2'b10, 32'h2222_2222};
      tbl[5]  = '{2'b10, 2'b10, 2'b10, 32'h2222_2222};
      tbl[6]  = '{2'b00, 2'b00, 2'b01, 32'h1111_1111};
      tbl[7]  = '{2'b11, 2'b01, 2'b10, 32'h2222_2222};
      tbl[8]  = '{2'b01, 2'b01, 2'b00, 32'h2222_2222};
      tbl[9]  = '{2'b11, 2'b10, 2'b01, 32'h1111_1111};
      tbl[10] = '{2'b00, 2'b00, 2'b01, 32'h1111_1111};
      tbl[11] = '{2'b00, 2'b00, 2'b10, 32'h2222_2222};
      req_write = 2'b00;
      req_addr  = {8'h02, 8'h01};
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         check("tbl_resp_valid", 64'(resp_valid), 64'(tbl[k].exp_resp));
         check("tbl_resp_data", 64'(resp_data), 64'(tbl[k].exp_data));
         req_valid = tbl[k].valid;
         #1;
         check("tbl_ready", 64'(req_ready), 64'(tbl[k].exp_ready));
         $display("vec %0d: valid=%b ready=%b resp_valid=%b resp_data=%h", k, req_valid,
                  req_ready, resp_valid, resp_data);
      end

      // Both requesters hold reads for 6 cycles: grants alternate 0,1,... and responses follow.
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (c >= 2) begin
            check("rr_resp_id", 64'(resp_valid), 64'(2'b01 << ((c - 2) % 2)));
            check("rr_resp_data", 64'(resp_data),
                  ((c - 2) % 2 == 0) ? 64'h1111_1111 : 64'h2222_2222);
         end
         req_valid = (c < 6) ? 2'b11 : 2'b00;
         #1;
         if (c < 6) check("rr_grant", 64'(req_ready), 64'(2'b01 << (c % 2)));
         $display("rr cycle %0d: ready=%b resp_valid=%b", c, req_ready, resp_valid);
      end

      do_op(1, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0, "wr10");
      do_op(1, 1'b0, 8'h10, 32'h0, 32'hDEAD_BEEF, "rd10");

      // Back-to-back: write then read of the same address on consecutive accepts.
      @(negedge clock);
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {8'h20, 8'h20};
      req_wdata = {32'h0, 32'h5};
      #1 check("b2b_ready_w", 64'(req_ready), 64'(2'b01));
      @(negedge clock);
      req_valid = 2'b10;
      #1 check("b2b_ready_r", 64'(req_ready), 64'(2'b10));
      @(negedge clock);
      req_valid = 2'b00;
      check("b2b_resp_w", 64'({resp_valid, resp_data}), {30'h0, 2'b01, 32'h0});
      @(negedge clock);
      check("b2b_resp_r", 64'({resp_valid, resp_data}), {30'h0, 2'b10, 32'h5});
      $display("b2b: read of 0x20 returned %h", resp_data);

      // Reset during the command cycle of a write discards it.
      @(negedge clock);
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {8'h00, 8'h30};
      req_wdata = {32'h0, 32'hBAD0_BAD0};
      @(negedge clock);
      req_valid = 2'b00;
      reset = 1'b1;
      #1 check("rstmid_wen", 64'(mem_writeEnable), 64'h0);
      @(negedge clock);
      check("rstmid_resp_valid", 64'(resp_valid), 64'h0);
      reset = 1'b0;
      @(negedge clock);
      check("rstmid_resp_valid2", 64'(resp_valid), 64'h0);
      check("rstmid_mem30", 64'(tb_mem[8'h30]), 64'h0);
      $display("reset mid-write: mem[0x30]=%h", tb_mem[8'h30]);

`ifdef BSRAM_ARB_STATS_EN
      for (int i = 0; i < 3; i++) do_op(0, 1'b0, 8'h01, 32'h0, 32'h1111_1111, "stat0");
      for (int i = 0; i < 2; i++) do_op(1, 1'b0, 8'h02, 32'h0, 32'h2222_2222, "stat1");
      check("stat_r0", 64'(stat_grants[31:0]), 64'd3);
      check("stat_r1", 64'(stat_grants[63:32]), 64'd2);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("stat_clear", 64'(stat_grants), 64'h0);
      $display("stats: grants after reset=%h", stat_grants);
`endif

      // Random traffic against a transaction-level model.
      @(negedge clock);
      reset = 1'b1;
      req_valid = '0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      for (int i = 0; i < NR; i++) hold[i] = 1'b0;
      rr_m   = 0;
      pend_v = 1'b0;
      exp_rv = '0;
      exp_rd = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         check("rnd_resp_valid", 64'(resp_valid), 64'(exp_rv));
         check("rnd_resp_data", 64'(resp_data), 64'(exp_rd));
         for (int i = 0; i < NR; i++) begin
            if (!hold[i] && $urandom_range(0, 2) != 0) begin
               hold[i] = 1'b1;
               hw[i]   = 1'($urandom_range(0, 1));
               ha[i]   = 8'($urandom_range(8'h40, 8'h47));
               hd[i]   = $urandom;
            end
            req_valid[i] = hold[i];
            req_write[i] = hw[i];
            req_addr[i*AW +: AW]  = ha[i];
            req_wdata[i*DW +: DW] = hd[i];
         end
         #1;
         win = -1;
         for (int k = 0; k < NR; k++) begin
            int j;
            j = (rr_m + k) % NR;
            if (win < 0 && hold[j]) win = j;
         end
         check("rnd_ready", 64'(req_ready), (win < 0) ? 64'h0 : 64'(1 << win));
         @(posedge clock);
         if (pend_v) begin
            exp_rv = 2'(1 << pend_id);
            if (pend_w) begin
               ref_mem[pend_a] = pend_d;
               exp_rd = '0;
            end else begin
               exp_rd = ref_mem[pend_a];
            end
         end else begin
            exp_rv = '0;
         end
         pend_v = (win >= 0);
         if (win >= 0) begin
            pend_id   = win;
            pend_w    = hw[win];
            pend_a    = ha[win];
            pend_d    = hd[win];
            hold[win] = 1'b0;
            rr_m      = (win + 1) % NR;
            $display("rnd %0d: accept req%0d %s addr=%h data=%h", c, win,
                     pend_w ? "wr" : "rd", pend_a, pend_d);
         end
      end
      @(negedge clock);
      req_valid = '0;
      check("rnd_final_resp_valid", 64'(resp_valid), 64'(exp_rv));
      check("rnd_final_resp_data", 64'(resp_data), 64'(exp_rd));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bsram_arbiter.md
Name: bsram_arbiter

Overview:
Round-robin arbiter and sequencer that shares one BSRAM instance between NUM_REQ requesters, such as fetch, load/store and a debug loader. It accepts one request per cycle through a valid/ready handshake and registers it into a single command stage. That stage drives the BSRAM read or write port. Read data is then registered into a tagged response one cycle later. It sits between the core memory stages and a BSRAM, and owns every BSRAM control pin.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
DATA_WIDTH, 32, data word width; matches the BSRAM
ADDR_WIDTH, 8, word address width; matches the BSRAM

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request i is present
req_write  in  NUM_REQ  1 = write, 0 = read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_ready  out  NUM_REQ  one-hot grant; combinational from req_valid and rr_ptr
resp_valid  out  NUM_REQ  one-hot completion pulse, registered
resp_data  out  DATA_WIDTH  read data; qualified by resp_valid; 0 for writes
mem_readEnable  out  1  to BSRAM readEnable
mem_readAddress  out  ADDR_WIDTH  to BSRAM readAddress
mem_readData  in  DATA_WIDTH  from BSRAM readData (same-cycle read)
mem_writeEnable  out  1  to BSRAM writeEnable
mem_writeAddress  out  ADDR_WIDTH  to BSRAM writeAddress
mem_writeData  out  DATA_WIDTH  to BSRAM writeData

Behaviour:
- Reset: rr_ptr=0, cmd_valid=0, resp_valid=0, resp_data=0. req_ready is all-zero while reset=1. All mem_* enables are 0 while reset=1.
- Arbitration: the winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready is one-hot at the winner and zero if no requester is valid.
- Accept: when req_valid[w]&req_ready[w], the command register loads {id=w, write, addr, wdata}, cmd_valid<=1, and rr_ptr<=(w+1) mod NUM_REQ. With no accept, cmd_valid<=0 and rr_ptr holds.
- Command cycle, when cmd_valid=1:
  - read: mem_readEnable=1 and mem_readAddress=cmd_addr.
  - write: mem_writeEnable=1 with cmd_addr and cmd_wdata.
  - Exactly one mem enable is high; both are 0 when cmd_valid=0.
  - Unused mem address/data outputs are driven 0.
- Response: at the end of the command cycle, resp_valid[cmd_id]<=1 for one cycle. resp_data<=mem_readData for a read, 0 for a write. resp_data holds its value when resp_valid=0.
- Latency: accept edge E0, command cycle E0..E1, resp_valid high E1..E2. Throughput is 1 op/cycle with no bubbles.
- Ordering: ops complete in accept order. A write accepted at E0 is visible to a read accepted at E1. No forwarding path is needed because a single op runs per cycle.
- Requester obligation: hold req_valid/addr/wdata stable until ready. The arbiter never drops a request that has been accepted (except on reset).
- Starvation bound: a held request is granted within NUM_REQ cycles.
- NUM_REQ=1: req_ready=req_valid and rr_ptr stays 0.
- Reset mid-operation: an in-flight command is discarded and its write never reaches the BSRAM. A pending resp_valid is cleared. The first acceptance after reset is at the first edge with reset=0.

Optional Feature:
BSRAM_ARB_STATS_EN
- Defined: adds a NUM_REQ*32 output stat_grants. It holds per-requester accept counters; they clear on reset, increment on each accept, and wrap at 2^32. Also adds a 1-bit input report which, when high, $display's the counters and the current cmd register each cycle.
- Undefined: no counters, no stat_grants or report ports, no $display.

Decomposition:
- Package bsram_arb_pkg holds:
  - function clog2_min1(n), giving the id/pointer width (minimum 1);
  - localparams CMD_READ=0 and CMD_WRITE=1;
  - a packed struct cmd_t {id, write, addr, wdata}.
- One combinational sub-module, rr_pick, takes {valid vector, rr_ptr} and returns a one-hot grant and a binary winner.
- The FSM-free pipeline registers stay in bsram_arbiter.

Test Plan:
- Reset then idle: resp_valid=0, mem enables 0, req_ready=0 for 5 cycles.
- Requester 1 write addr 0x10 data 0xDEADBEEF, then read 0x10 -> resp_valid[1] at accept+1 both times; the read returns resp_data=0xDEADBEEF.
- Both requesters hold continuous reads (r0 addr 0x01, r1 addr 0x02) for 6 cycles -> grant order 0,1,0,1,0,1 and the response ids match.
- Back-to-back: r0 writes 0x20=0x5 at E0 and r1 reads 0x20 at E1 -> r1 sees 0x5.
- Reset asserted in the command cycle of a write to 0x30 (prior value 0x0) -> BSRAM 0x30 stays 0x0 and no resp_valid.
- With BSRAM_ARB_STATS_EN: 3 grants to r0 and 2 to r1 -> stat_grants shows 3 and 2; reset clears both.
